// File: rtl/serial_shift_right_pkg.sv
// Shared constants and state encoding for the serial right shifter and its
// companion barrel shifter.
package serial_shift_right_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned SHW_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_shift_right_pkg

// File: rtl/serial_shift_right_step.sv
// Single-bit right shift stage: logical (zero fill) or rotate (bit 0 wraps to MSB).
module shift_step_right #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             rot,
  output logic [WIDTH-1:0] q_c
);

  assign q_c = {(rot ? d[0] : 1'b0), d[WIDTH-1:1]};

endmodule : shift_step_right

// File: rtl/serial_shift_right.sv
// Iterative right shifter, one bit per clock, valid/ready on both sides.
// Define SERIAL_SHIFT_RIGHT_ROTATE_EN to honour the rot input (rotate right).
module serial_shift_right
  import serial_shift_right_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   ctrl,
  input  logic             rot,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic             rot_q;
  logic             rot_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             out_valid_nxt;
  logic             in_ready_nxt;
  logic [WIDTH-1:0] step_c;

  shift_step_right #(.WIDTH(WIDTH)) u_step (
    .d   (data),
    .rot (rot_q),
    .q_c (step_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    data_nxt      = data;
    cnt_nxt       = cnt;
    rot_nxt       = rot_q;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    in_ready_nxt  = in_ready;

    case (state)
      IDLE: begin
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
        if (in_valid && in_ready) begin
          data_nxt     = in;
          cnt_nxt      = ctrl;
          rot_nxt      = rot;
          in_ready_nxt = 1'b0;
          if (ctrl == '0) begin
            // Zero shift goes straight to the result with the operand untouched
            state_nxt     = DONE;
            out_nxt       = in;
            out_valid_nxt = 1'b1;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end

      SHIFT: begin
        in_ready_nxt = 1'b0;
        data_nxt     = step_c;
        cnt_nxt      = SHW'(cnt - 1'b1);
        if (cnt == SHW'(1)) begin
          state_nxt     = DONE;
          out_nxt       = step_c;
          out_valid_nxt = 1'b1;
        end
      end

      DONE: begin
        in_ready_nxt = 1'b0;
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      data      <= data_nxt;
      cnt       <= cnt_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

`ifdef SERIAL_SHIFT_RIGHT_ROTATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else begin
      rot_q <= rot_nxt;
    end
  end
`else
  // Rotate disabled: every operation is a logical shift
  logic unused_rot;
  assign unused_rot = rot ^ rot_nxt;
  assign rot_q      = 1'b0;
`endif

endmodule : serial_shift_right
